// File: rtl/aurora_hls_nfc_pkg.sv
// Shared NFC message codes and arbiter state encoding for the Aurora NFC pause arbiter.
package aurora_hls_nfc_pkg;

    localparam logic [15:0] NFC_XOFF = 16'hFFFF;
    localparam logic [15:0] NFC_XON  = 16'h0000;

    typedef enum logic [2:0] {
        IDLE_ON,
        SEND_XOFF,
        PAUSED,
        SEND_XON,
        SEND_REFRESH
    } nfc_state_t;

endpackage

// File: rtl/aurora_hls_nfc_arb_refresh_timer.sv
// Refresh timer: counts enabled cycles after a clear and flags the last one (CYCLES-1).
module aurora_hls_nfc_refresh_timer #(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW   = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] r_count;

    // Saturates at LAST so a stalled expiry stays asserted until cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/aurora_hls_nfc_arb.sv
// Aurora NFC pause arbiter: ORs pause requests into an XOFF/XON handshake on the NFC stream.
// Define AURORA_HLS_NFC_REFRESH_EN to re-send XOFF every REFRESH_CYCLES paused cycles.
module aurora_hls_nfc_arb
    import aurora_hls_nfc_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int REFRESH_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               counter_reset,
    input  logic [NUM_REQ-1:0] req_pause,
    output logic               s_axi_nfc_tvalid,
    input  logic               s_axi_nfc_tready,
    output logic [15:0]        s_axi_nfc_tdata,
    output logic               link_paused,
    output logic [31:0]        xoff_count,
    output logic [31:0]        xon_count,
    output logic [31:0]        refresh_count
);

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("aurora_hls_nfc_arb: NUM_REQ must be 1..8");
    end
    if (REFRESH_CYCLES < 2) begin : g_bad_refresh_cycles
        $error("aurora_hls_nfc_arb: REFRESH_CYCLES must be at least 2");
    end

    nfc_state_t  r_state;
    nfc_state_t  w_next_state;
    logic        r_tvalid;
    logic [15:0] r_tdata;
    logic        r_link_paused;
    logic [31:0] r_xoff_count;
    logic [31:0] r_xon_count;
    logic        w_next_tvalid;
    logic [15:0] w_next_tdata;
    logic        w_agg;
    logic        w_accept;

    assign w_agg    = |req_pause;
    assign w_accept = r_tvalid && s_axi_nfc_tready;

`ifdef AURORA_HLS_NFC_REFRESH_EN
    logic        w_expired;
    logic [31:0] r_refresh_count;

    // Held clear outside PAUSED, so every entry to PAUSED starts from zero.
    aurora_hls_nfc_refresh_timer #(
        .CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state != PAUSED),
        .enable  (r_state == PAUSED),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst || counter_reset) begin
            r_refresh_count <= '0;
        end else if (w_accept && (r_state == SEND_REFRESH)) begin
            r_refresh_count <= r_refresh_count + 32'd1;
        end
    end

    assign refresh_count = r_refresh_count;
`else
    assign refresh_count = '0;
`endif

    // Send states leave only on tready, which keeps a pending message stable.
    always_comb begin
        w_next_state  = r_state;
        w_next_tvalid = 1'b0;
        w_next_tdata  = NFC_XON;
        case (r_state)
            IDLE_ON:      if (w_agg) w_next_state = SEND_XOFF;
            SEND_XOFF:    if (s_axi_nfc_tready) w_next_state = PAUSED;
            PAUSED: begin
                if (!w_agg) begin
                    w_next_state = SEND_XON;
                end
`ifdef AURORA_HLS_NFC_REFRESH_EN
                else if (w_expired) begin
                    w_next_state = SEND_REFRESH;
                end
`endif
            end
            SEND_XON:     if (s_axi_nfc_tready) w_next_state = w_agg ? SEND_XOFF : IDLE_ON;
            SEND_REFRESH: if (s_axi_nfc_tready) w_next_state = PAUSED;
            default:      w_next_state = IDLE_ON;
        endcase
        case (w_next_state)
            SEND_XOFF, SEND_REFRESH: begin
                w_next_tvalid = 1'b1;
                w_next_tdata  = NFC_XOFF;
            end
            SEND_XON: begin
                w_next_tvalid = 1'b1;
                w_next_tdata  = NFC_XON;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE_ON;
            r_tvalid      <= 1'b0;
            r_tdata       <= NFC_XON;
            r_link_paused <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tvalid <= w_next_tvalid;
            r_tdata  <= w_next_tdata;
            if (w_accept && (r_state == SEND_XOFF)) begin
                r_link_paused <= 1'b1;
            end else if (w_accept && (r_state == SEND_XON)) begin
                r_link_paused <= 1'b0;
            end
        end
    end

    // Clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || counter_reset) begin
            r_xoff_count <= '0;
            r_xon_count  <= '0;
        end else begin
            if (w_accept && (r_state == SEND_XOFF)) r_xoff_count <= r_xoff_count + 32'd1;
            if (w_accept && (r_state == SEND_XON))  r_xon_count  <= r_xon_count + 32'd1;
        end
    end

    assign s_axi_nfc_tvalid = r_tvalid;
    assign s_axi_nfc_tdata  = r_tdata;
    assign link_paused      = r_link_paused;
    assign xoff_count       = r_xoff_count;
    assign xon_count        = r_xon_count;

endmodule

// File: tb/tb_aurora_hls_nfc_arb.sv
// Self-checking bench for aurora_hls_nfc_arb: directed scenarios plus a randomized run against a message-level model.
module tb_aurora_hls_nfc_arb;

    localparam int NREQ = 2;
    localparam int RC   = 16;
`ifdef AURORA_HLS_NFC_REFRESH_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif
    localparam int K_XOFF = 1;
    localparam int K_XON  = 2;
    localparam int K_REF  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            counter_reset;
    logic [NREQ-1:0] req_pause;
    logic            s_axi_nfc_tvalid;
    logic            s_axi_nfc_tready;
    logic [15:0]     s_axi_nfc_tdata;
    logic            link_paused;
    logic [31:0]     xoff_count;
    logic [31:0]     xon_count;
    logic [31:0]     refresh_count;

    int total = 0;
    int bad   = 0;

    // Model: link view = one optional pending message plus the partner's paused flag.
    bit          mValid;
    int          mKind;
    bit          mPaused;
    int          mTimer;
    logic [31:0] mXoff;
    logic [31:0] mXon;
    logic [31:0] mRef;

    aurora_hls_nfc_arb #(
        .NUM_REQ        (NREQ),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .counter_reset    (counter_reset),
        .req_pause        (req_pause),
        .s_axi_nfc_tvalid (s_axi_nfc_tvalid),
        .s_axi_nfc_tready (s_axi_nfc_tready),
        .s_axi_nfc_tdata  (s_axi_nfc_tdata),
        .link_paused      (link_paused),
        .xoff_count       (xoff_count),
        .xon_count        (xon_count),
        .refresh_count    (refresh_count)
    );

    always #5 clk = ~clk;

    function automatic void modelStep(input logic [NREQ-1:0] req, input logic rdy, input logic cr, input logic rs);
        bit agg;
        agg = |req;
        if (rs) begin
            mValid = 0; mKind = 0; mPaused = 0; mTimer = 0;
            mXoff = '0; mXon = '0; mRef = '0;
            return;
        end
        if (mValid) begin
            if (rdy) begin
                if (mKind == K_XOFF) begin
                    mXoff = mXoff + 32'd1; mPaused = 1; mValid = 0; mTimer = 0;
                end else if (mKind == K_REF) begin
                    mRef = mRef + 32'd1; mValid = 0; mTimer = 0;
                end else begin
                    mXon = mXon + 32'd1; mPaused = 0;
                    if (agg) mKind = K_XOFF;
                    else     mValid = 0;
                end
            end
        end else if (!mPaused) begin
            if (agg) begin mValid = 1; mKind = K_XOFF; end
        end else if (!agg) begin
            mValid = 1; mKind = K_XON;
        end else if (REF_EN && mTimer == RC - 1) begin
            mValid = 1; mKind = K_REF;
        end else begin
            mTimer = mTimer + 1;
        end
        if (cr) begin
            mXoff = '0; mXon = '0; mRef = '0;
        end
    endfunction

    function automatic logic [15:0] expData();
        return (mValid && mKind != K_XON) ? 16'hFFFF : 16'h0000;
    endfunction

    task automatic applyStimulus(input logic [NREQ-1:0] req, input logic rdy, input logic cr, input logic rs);
        req_pause        = req;
        s_axi_nfc_tready = rdy;
        counter_reset    = cr;
        rst              = rs;
        @(posedge clk);
        modelStep(req, rdy, cr, rs);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        total++;
        if (s_axi_nfc_tvalid !== 1'b0 || s_axi_nfc_tdata !== 16'h0000 || link_paused !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h lp=%b, expected v=0 d=0000 lp=0",
                     s_axi_nfc_tvalid, s_axi_nfc_tdata, link_paused);
        end
        total++;
        if (xoff_count !== 32'd0 || xon_count !== 32'd0 || refresh_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_counters: got %0d/%0d/%0d, expected 0/0/0", xoff_count, xon_count, refresh_count);
        end
    endtask

    task automatic test_xoff_hold();
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
            total++;
            if (s_axi_nfc_tvalid !== 1'b1 || s_axi_nfc_tdata !== 16'hFFFF) begin
                bad++;
                $display("[TB] FAIL xoff_hold cycle %0d: got v=%b d=%h, expected v=1 d=ffff", i, s_axi_nfc_tvalid, s_axi_nfc_tdata);
            end
        end
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        total++;
        if (xoff_count !== 32'd1 || link_paused !== 1'b1 || s_axi_nfc_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL xoff_accept: got xoff=%0d lp=%b v=%b, expected xoff=1 lp=1 v=0", xoff_count, link_paused, s_axi_nfc_tvalid);
        end
    endtask

    task automatic test_back_to_back();
        resetDut();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (xoff_count !== 32'd1 || xon_count !== 32'd1 || link_paused !== 1'b0 || s_axi_nfc_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL back_to_back: got xoff=%0d xon=%0d lp=%b v=%b, expected 1 1 0 0",
                     xoff_count, xon_count, link_paused, s_axi_nfc_tvalid);
        end
    endtask

    task automatic test_refresh();
        resetDut();
        for (int i = 0; i < 100; i++) applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        total++;
        if (refresh_count !== (REF_EN ? 32'd5 : 32'd0) || xoff_count !== 32'd1 || link_paused !== 1'b1) begin
            bad++;
            $display("[TB] FAIL refresh: got ref=%0d xoff=%0d lp=%b, expected ref=%0d xoff=1 lp=1",
                     refresh_count, xoff_count, link_paused, REF_EN ? 5 : 0);
        end
    endtask

    task automatic test_drop_pending();
        resetDut();
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
            total++;
            if (s_axi_nfc_tvalid !== 1'b1 || s_axi_nfc_tdata !== 16'hFFFF) begin
                bad++;
                $display("[TB] FAIL drop_hold cycle %0d: got v=%b d=%h, expected v=1 d=ffff", i, s_axi_nfc_tvalid, s_axi_nfc_tdata);
            end
        end
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (xoff_count !== 32'd1 || link_paused !== 1'b1 || s_axi_nfc_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drop_xoff: got xoff=%0d lp=%b v=%b, expected 1 1 0", xoff_count, link_paused, s_axi_nfc_tvalid);
        end
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (s_axi_nfc_tvalid !== 1'b1 || s_axi_nfc_tdata !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL drop_xon_offer: got v=%b d=%h, expected v=1 d=0000", s_axi_nfc_tvalid, s_axi_nfc_tdata);
        end
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (xoff_count !== 32'd1 || xon_count !== 32'd1 || link_paused !== 1'b0 || s_axi_nfc_tvalid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL drop_xon: got xoff=%0d xon=%0d lp=%b v=%b, expected 1 1 0 0",
                     xoff_count, xon_count, link_paused, s_axi_nfc_tvalid);
        end
    endtask

    task automatic test_counter_clear();
        resetDut();
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
        total++;
        if (xoff_count !== 32'd0 || xon_count !== 32'd0 || refresh_count !== 32'd0 ||
            s_axi_nfc_tvalid !== 1'b0 || link_paused !== 1'b0) begin
            bad++;
            $display("[TB] FAIL counter_clear: got xoff=%0d xon=%0d ref=%0d v=%b lp=%b, expected 0 0 0 0 0",
                     xoff_count, xon_count, refresh_count, s_axi_nfc_tvalid, link_paused);
        end
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0);
        total++;
        if (s_axi_nfc_tvalid !== 1'b1 || s_axi_nfc_tdata !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL clear_fsm_idle: got v=%b d=%h, expected v=1 d=ffff", s_axi_nfc_tvalid, s_axi_nfc_tdata);
        end
    endtask

    task automatic test_reset_mid();
        resetDut();
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        total++;
        if (s_axi_nfc_tvalid !== 1'b0 || s_axi_nfc_tdata !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL reset_mid_drop: got v=%b d=%h, expected v=0 d=0000", s_axi_nfc_tvalid, s_axi_nfc_tdata);
        end
        applyStimulus(2'b00, 1'b1, 1'b0, 1'b0);
        total++;
        if (s_axi_nfc_tvalid !== 1'b0 || xon_count !== 32'd0 || xoff_count !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_no_xon: got v=%b xon=%0d xoff=%0d, expected 0 0 0", s_axi_nfc_tvalid, xon_count, xoff_count);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] req;
        logic            rdy;
        logic            cr;
        logic            rs;
        int              cycleBad;
        resetDut();
        req = '0;
        cycleBad = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            rdy = ($urandom_range(0, 3) != 0);
            cr  = ($urandom_range(0, 99) == 0);
            rs  = ($urandom_range(0, 499) == 0);
            applyStimulus(req, rdy, cr, rs);
            total++;
            if (s_axi_nfc_tvalid !== mValid || s_axi_nfc_tdata !== expData() || link_paused !== mPaused) begin
                bad++;
                cycleBad++;
                if (cycleBad <= 10)
                    $display("[TB] FAIL rand_handshake cycle %0d: got v=%b d=%h lp=%b, expected v=%b d=%h lp=%b",
                             i, s_axi_nfc_tvalid, s_axi_nfc_tdata, link_paused, mValid, expData(), mPaused);
            end
            total++;
            if (xoff_count !== mXoff || xon_count !== mXon || refresh_count !== mRef) begin
                bad++;
                cycleBad++;
                if (cycleBad <= 10)
                    $display("[TB] FAIL rand_counters cycle %0d: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                             i, xoff_count, xon_count, refresh_count, mXoff, mXon, mRef);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        counter_reset    = 1'b0;
        req_pause        = '0;
        s_axi_nfc_tready = 1'b0;
        modelStep('0, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_xoff_hold();
        test_back_to_back();
        test_refresh();
        test_drop_pending();
        test_counter_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
